hrm_host_link: RTL and testbench
================================

Name: hrm_host_link

Overview:
- Byte-stream command bridge between a host serial link (UART rx/tx byte interfaces) and the hrmcpu host-side ports.
- Decodes single-byte commands with 0-2 argument bytes. Each command performs one action: push INBOX, pop OUTBOX, dump a component, single-step, or set debug mode. It then returns a 1-2 byte reply on the tx stream.
- Sits upstream of hrmcpu on the INBOX/control side and downstream of it on the OUTBOX/dump side.

Parameters:
- ACK, 8'h06, reply byte for success.
- NAK, 8'h15, reply byte for failure or unknown command.
- TIMEOUT_CYCLES, 24'd1200000, inter-byte/stall timeout. Used only with HOST_LINK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-low (0 = reset)
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx_data this cycle
- tx_data  out  8  reply byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts tx_data this cycle
- cpu_in_data  out  8  byte for INBOX
- cpu_in_wr  out  1  INBOX write strobe
- cpu_in_full  in  1  INBOX full
- cpu_out_data  in  8  OUTBOX head byte, valid while cpu_out_empty=0
- cpu_out_empty  in  1  OUTBOX empty
- cpu_out_rd  out  1  OUTBOX pop strobe
- cpu_dmp_chip_select  out  3  dump component select
- cpu_dmp_fifo_pos  out  5  dump FIFO position
- cpu_dmp_data  in  8  dump value
- cpu_dmp_valid  in  1  dump value valid
- cpu_debug  out  1  CPU debug (step) mode
- cpu_nxtInstr  out  1  single-step pulse

Behaviour:
- Reset (i_rst=0 at clk edge):
  - State=IDLE.
  - All outputs 0, except rx_ready=1 and cpu_debug=1 (CPU starts halted in debug).
  - Any in-flight command is abandoned with no reply.
  - Strobes cleared in the same cycle.
- Handshake rules:
  - A byte transfers when rx_valid&rx_ready, or tx_valid&tx_ready, at the clock edge.
  - rx_ready=1 only in IDLE, ARG1 and ARG2.
  - tx_valid is held with tx_data stable until accepted.
- States:
  - IDLE:
    - 'I'(8'h49) -> ARG1
    - 'D'(8'h44) -> ARG1
    - 'B'(8'h42) -> ARG1
    - 'O'(8'h4F) -> POP
    - 'S'(8'h53) -> STEP
    - other -> SEND with NAK
  - ARG1:
    - 'I': latch cpu_in_data -> PUSH.
    - 'D': latch cpu_dmp_chip_select=arg[2:0] -> ARG2.
    - 'B': cpu_debug<=arg[0] -> SEND ACK.
  - ARG2 ('D'): latch cpu_dmp_fifo_pos=arg[4:0] -> DSET.
  - PUSH:
    - Waits while cpu_in_full=1.
    - Asserts cpu_in_wr for exactly 1 cycle, in the first cycle with cpu_in_full=0 -> SEND ACK.
  - POP:
    - If cpu_out_empty=1 -> SEND NAK (1 byte).
    - Else capture cpu_out_data into the reply buffer, pulse cpu_out_rd for 1 cycle -> SEND ACK then data (2 bytes).
  - DSET: one settle cycle with select/pos stable -> DSAMP.
  - DSAMP: capture {7'b0,cpu_dmp_valid} and cpu_dmp_data -> SEND 2 bytes.
  - STEP: cpu_nxtInstr=1 for exactly 1 cycle -> SEND ACK.
  - SEND:
    - Emits byte0, then byte1 if the reply length is 2 -> IDLE.
    - Next command byte is accepted the cycle after the last tx acceptance.
- Dump select/pos outputs hold their last value after the command completes.
- Strobes (cpu_in_wr, cpu_out_rd, cpu_nxtInstr) are never asserted for more than 1 cycle per command and are never asserted simultaneously.
- An rx byte arriving outside IDLE/ARG states is not accepted. It is left to upstream backpressure.

Optional Feature:
- HOST_LINK_TIMEOUT_EN defined:
  - A down-counter loads TIMEOUT_CYCLES on entry to ARG1, ARG2 or PUSH, and on every accepted rx byte.
  - If it reaches 0 in ARG1/ARG2/PUSH, the command aborts -> SEND NAK. No cpu_in_wr is issued and settings latched by the partial command remain.
- Not defined: no counter; ARG/PUSH wait indefinitely.

Test Plan:
- Reset low 2 cycles -> rx_ready=1, tx_valid=0, cpu_debug=1, all strobes 0. Send 'I',8'h2A with cpu_in_full=0 -> cpu_in_data=8'h2A, one-cycle cpu_in_wr, tx 8'h06.
- 'I',8'h05 with cpu_in_full=1 for 10 cycles -> no cpu_in_wr until full drops, then exactly one pulse and ACK. With HOST_LINK_TIMEOUT_EN, TIMEOUT_CYCLES=16 and full held -> NAK after 16 cycles, no wr.
- 'O' with cpu_out_empty=0, cpu_out_data=8'hF3 -> one-cycle cpu_out_rd, tx 8'h06 then 8'hF3. 'O' with empty=1 -> tx 8'h15 only, no rd.
- 'D',8'h00,8'h03 with cpu_dmp_valid=0, data=8'h77 -> select=0, pos=3, tx 8'h00 then 8'h77. Repeat with tx_ready low 5 cycles -> tx_data stable, no byte lost.
- 'B',8'h00 then 'S' -> cpu_debug=0, tx ACK. Then one-cycle cpu_nxtInstr, tx ACK. Unknown byte 8'h5A -> tx 8'h15, back to IDLE.
- Reset asserted mid-PUSH wait and mid-SEND -> next cycle IDLE, tx_valid=0, no strobe emitted.

Source files
------------

// File: rtl/hrm_host_link.sv
// hrm_host_link: byte-stream command bridge between a host serial link and
// the hrmcpu host-side ports.
//
// Commands (first byte), arguments and replies:
//   'I' arg          -> push arg into INBOX (waits while full) -> ACK
//   'O'              -> pop OUTBOX: ACK + data, or NAK when empty
//   'D' sel pos      -> set dump select/pos, settle, sample -> {valid} + data
//   'B' arg          -> cpu_debug <= arg[0] -> ACK
//   'S'              -> one cpu_nxtInstr pulse -> ACK
//   anything else    -> NAK
//
// Ports:
//   clk, i_rst (sync, active-low)
//   rx_data/rx_valid/rx_ready   host byte input stream
//   tx_data/tx_valid/tx_ready   reply byte output stream
//   cpu_in_*                    INBOX write side
//   cpu_out_*                   OUTBOX read side
//   cpu_dmp_*                   component dump select/pos and sampled value
//   cpu_debug, cpu_nxtInstr     debug mode and single-step pulse
//
// Optional build macro HOST_LINK_TIMEOUT_EN: when defined, a down-counter
// aborts a command stalled in ARG1/ARG2/PUSH for TIMEOUT_CYCLES with a NAK.
module hrm_host_link #(
    parameter logic [7:0]  ACK            = 8'h06,
    parameter logic [7:0]  NAK            = 8'h15,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1200000
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] cpu_in_data,
    output logic       cpu_in_wr,
    input  logic       cpu_in_full,
    input  logic [7:0] cpu_out_data,
    input  logic       cpu_out_empty,
    output logic       cpu_out_rd,
    output logic [2:0] cpu_dmp_chip_select,
    output logic [4:0] cpu_dmp_fifo_pos,
    input  logic [7:0] cpu_dmp_data,
    input  logic       cpu_dmp_valid,
    output logic       cpu_debug,
    output logic       cpu_nxtInstr
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARG1, S_ARG2, S_PUSH, S_POP, S_DSET, S_DSAMP, S_STEP, S_SEND
    } state_t;

    localparam logic [7:0] C_IN   = 8'h49;
    localparam logic [7:0] C_DUMP = 8'h44;
    localparam logic [7:0] C_DBG  = 8'h42;
    localparam logic [7:0] C_POP  = 8'h4F;
    localparam logic [7:0] C_STEP = 8'h53;

    state_t     r_state;
    logic [7:0] r_cmd;
    logic [7:0] r_buf0;
    logic [7:0] r_buf1;
    logic       r_len2;   // reply is two bytes
    logic       r_idx;    // reply byte currently offered
    logic       w_wait_state;
    logic       w_tmo_hit;

    assign rx_ready = (r_state == S_IDLE) || (r_state == S_ARG1) || (r_state == S_ARG2);
    assign tx_valid = (r_state == S_SEND);
    assign tx_data  = r_idx ? r_buf1 : r_buf0;

    // States in which the bridge is waiting on something external.
    assign w_wait_state = (r_state == S_ARG1) || (r_state == S_ARG2) || (r_state == S_PUSH);

`ifdef HOST_LINK_TIMEOUT_EN
    logic [23:0] r_tmo;

    // Held at full count outside the wait states, so entering one starts a
    // fresh window; every accepted byte restarts it as well.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_tmo <= TIMEOUT_CYCLES;
        end else if (!w_wait_state || (rx_valid && rx_ready)) begin
            r_tmo <= TIMEOUT_CYCLES;
        end else if (r_tmo != 24'd0) begin
            r_tmo <= r_tmo - 24'd1;
        end
    end

    assign w_tmo_hit = w_wait_state && (r_tmo == 24'd0);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_state             <= S_IDLE;
            r_cmd               <= 8'h00;
            r_buf0              <= 8'h00;
            r_buf1              <= 8'h00;
            r_len2              <= 1'b0;
            r_idx               <= 1'b0;
            cpu_in_data         <= 8'h00;
            cpu_in_wr           <= 1'b0;
            cpu_out_rd          <= 1'b0;
            cpu_dmp_chip_select <= 3'd0;
            cpu_dmp_fifo_pos    <= 5'd0;
            cpu_debug           <= 1'b1;
            cpu_nxtInstr        <= 1'b0;
        end else begin
            // Strobes are single-cycle: cleared unless set below.
            cpu_in_wr    <= 1'b0;
            cpu_out_rd   <= 1'b0;
            cpu_nxtInstr <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_idx <= 1'b0;
                    if (rx_valid) begin
                        r_cmd <= rx_data;
                        case (rx_data)
                            C_IN, C_DUMP, C_DBG: r_state <= S_ARG1;
                            C_POP:               r_state <= S_POP;
                            C_STEP:              r_state <= S_STEP;
                            default: begin
                                r_buf0  <= NAK;
                                r_len2  <= 1'b0;
                                r_state <= S_SEND;
                            end
                        endcase
                    end
                end

                S_ARG1: begin
                    if (rx_valid) begin
                        case (r_cmd)
                            C_IN: begin
                                cpu_in_data <= rx_data;
                                r_state     <= S_PUSH;
                            end
                            C_DUMP: begin
                                cpu_dmp_chip_select <= rx_data[2:0];
                                r_state             <= S_ARG2;
                            end
                            C_DBG: begin
                                cpu_debug <= rx_data[0];
                                r_buf0    <= ACK;
                                r_len2    <= 1'b0;
                                r_state   <= S_SEND;
                            end
                            default: begin
                                r_buf0  <= NAK;
                                r_len2  <= 1'b0;
                                r_state <= S_SEND;
                            end
                        endcase
                    end else if (w_tmo_hit) begin
                        r_buf0  <= NAK;
                        r_len2  <= 1'b0;
                        r_state <= S_SEND;
                    end
                end

                S_ARG2: begin
                    if (rx_valid) begin
                        cpu_dmp_fifo_pos <= rx_data[4:0];
                        r_state          <= S_DSET;
                    end else if (w_tmo_hit) begin
                        r_buf0  <= NAK;
                        r_len2  <= 1'b0;
                        r_state <= S_SEND;
                    end
                end

                S_PUSH: begin
                    if (!cpu_in_full) begin
                        cpu_in_wr <= 1'b1;
                        r_buf0    <= ACK;
                        r_len2    <= 1'b0;
                        r_state   <= S_SEND;
                    end else if (w_tmo_hit) begin
                        r_buf0  <= NAK;
                        r_len2  <= 1'b0;
                        r_state <= S_SEND;
                    end
                end

                S_POP: begin
                    if (cpu_out_empty) begin
                        r_buf0 <= NAK;
                        r_len2 <= 1'b0;
                    end else begin
                        r_buf0     <= ACK;
                        r_buf1     <= cpu_out_data;
                        r_len2     <= 1'b1;
                        cpu_out_rd <= 1'b1;
                    end
                    r_state <= S_SEND;
                end

                // Give the dump mux one cycle with select/pos stable.
                S_DSET: r_state <= S_DSAMP;

                S_DSAMP: begin
                    r_buf0  <= {7'b0, cpu_dmp_valid};
                    r_buf1  <= cpu_dmp_data;
                    r_len2  <= 1'b1;
                    r_state <= S_SEND;
                end

                S_STEP: begin
                    cpu_nxtInstr <= 1'b1;
                    r_buf0       <= ACK;
                    r_len2       <= 1'b0;
                    r_state      <= S_SEND;
                end

                S_SEND: begin
                    if (tx_ready) begin
                        if (!r_idx && r_len2) begin
                            r_idx <= 1'b1;
                        end else begin
                            r_idx   <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hrm_host_link.sv
module tb_hrm_host_link;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] cpu_in_data;
    logic       cpu_in_wr;
    logic       cpu_in_full;
    logic [7:0] cpu_out_data;
    logic       cpu_out_empty;
    logic       cpu_out_rd;
    logic [2:0] cpu_dmp_chip_select;
    logic [4:0] cpu_dmp_fifo_pos;
    logic [7:0] cpu_dmp_data;
    logic       cpu_dmp_valid;
    logic       cpu_debug;
    logic       cpu_nxtInstr;

    int total = 0;
    int bad   = 0;

    // Strobe activity recorded on every clock edge.
    int wr_cnt = 0, rd_cnt = 0, nx_cnt = 0;
    int wr_run = 0, rd_run = 0, nx_run = 0;
    int run_max = 0;
    int overlap = 0;

    hrm_host_link dut (
        .clk                 (clk),
        .i_rst               (i_rst),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .cpu_in_data         (cpu_in_data),
        .cpu_in_wr           (cpu_in_wr),
        .cpu_in_full         (cpu_in_full),
        .cpu_out_data        (cpu_out_data),
        .cpu_out_empty       (cpu_out_empty),
        .cpu_out_rd          (cpu_out_rd),
        .cpu_dmp_chip_select (cpu_dmp_chip_select),
        .cpu_dmp_fifo_pos    (cpu_dmp_fifo_pos),
        .cpu_dmp_data        (cpu_dmp_data),
        .cpu_dmp_valid       (cpu_dmp_valid),
        .cpu_debug           (cpu_debug),
        .cpu_nxtInstr        (cpu_nxtInstr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_in_wr)    wr_cnt <= wr_cnt + 1;
        if (cpu_out_rd)   rd_cnt <= rd_cnt + 1;
        if (cpu_nxtInstr) nx_cnt <= nx_cnt + 1;
        wr_run <= cpu_in_wr    ? wr_run + 1 : 0;
        rd_run <= cpu_out_rd   ? rd_run + 1 : 0;
        nx_run <= cpu_nxtInstr ? nx_run + 1 : 0;
        if (cpu_in_wr    && wr_run + 1 > run_max) run_max <= wr_run + 1;
        if (cpu_out_rd   && rd_run + 1 > run_max) run_max <= rd_run + 1;
        if (cpu_nxtInstr && nx_run + 1 > run_max) run_max <= nx_run + 1;
        if (int'(cpu_in_wr) + int'(cpu_out_rd) + int'(cpu_nxtInstr) > 1) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte until the bridge accepts it (bounded).
    task automatic send_byte(input logic [7:0] b, input string tag);
        bit done = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (rx_ready) done = 1;
            tick();
        end
        rx_valid = 1'b0;
        if (!done) check({tag, "_rx_timeout"}, 32'd0, 32'd1);
    endtask

    // Accept one reply byte and compare it (bounded).
    task automatic recv_byte(input logic [7:0] exp, input string tag);
        bit done = 0;
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (tx_valid) begin
                check(tag, {24'd0, tx_data}, {24'd0, exp});
                done = 1;
            end
            tick();
        end
        if (!done) check({tag, "_tx_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int wr0, rd0, nx0;
        logic [7:0] held;
        bit stable;

        i_rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        cpu_in_full = 1'b0; cpu_out_data = 8'h00; cpu_out_empty = 1'b1;
        cpu_dmp_data = 8'h00; cpu_dmp_valid = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_debug",    {31'd0, cpu_debug}, 32'd1);
        check("rst_strobes",  {29'd0, cpu_in_wr, cpu_out_rd, cpu_nxtInstr}, 32'd0);
        check("rst_in_data",  {24'd0, cpu_in_data}, 32'd0);
        i_rst = 1'b1;
        tick();

        // INBOX push, not full
        wr0 = wr_cnt;
        send_byte(8'h49, "i1_cmd");
        send_byte(8'h2A, "i1_arg");
        recv_byte(8'h06, "i1_ack");
        check("i1_in_data", {24'd0, cpu_in_data}, 32'h2A);
        check("i1_wr_count", wr_cnt - wr0, 32'd1);

        // INBOX push, full for 10 cycles
        cpu_in_full = 1'b1;
        wr0 = wr_cnt;
        send_byte(8'h49, "i2_cmd");
        send_byte(8'h05, "i2_arg");
        repeat (10) tick();
        check("i2_wr_while_full", wr_cnt - wr0, 32'd0);
        check("i2_no_reply_while_full", {31'd0, tx_valid}, 32'd0);
        cpu_in_full = 1'b0;
        recv_byte(8'h06, "i2_ack");
        check("i2_wr_count", wr_cnt - wr0, 32'd1);
        check("i2_in_data", {24'd0, cpu_in_data}, 32'h05);

        // OUTBOX pop, non-empty
        cpu_out_empty = 1'b0; cpu_out_data = 8'hF3;
        rd0 = rd_cnt;
        send_byte(8'h4F, "o1_cmd");
        recv_byte(8'h06, "o1_ack");
        recv_byte(8'hF3, "o1_data");
        check("o1_rd_count", rd_cnt - rd0, 32'd1);

        // OUTBOX pop, empty
        cpu_out_empty = 1'b1;
        rd0 = rd_cnt;
        send_byte(8'h4F, "o2_cmd");
        recv_byte(8'h15, "o2_nak");
        check("o2_single_byte", {31'd0, tx_valid}, 32'd0);
        check("o2_rd_count", rd_cnt - rd0, 32'd0);

        // Dump sel 0 pos 3
        cpu_dmp_valid = 1'b0; cpu_dmp_data = 8'h77;
        send_byte(8'h44, "d1_cmd");
        send_byte(8'h00, "d1_sel");
        send_byte(8'h03, "d1_pos");
        recv_byte(8'h00, "d1_valid");
        recv_byte(8'h77, "d1_data");
        check("d1_sel", {29'd0, cpu_dmp_chip_select}, 32'd0);
        check("d1_pos", {27'd0, cpu_dmp_fifo_pos}, 32'd3);

        // Dump sel 6 pos 0x0A with tx stalled for 5 cycles
        cpu_dmp_valid = 1'b1; cpu_dmp_data = 8'hC4;
        tx_ready = 1'b0;
        send_byte(8'h44, "d2_cmd");
        send_byte(8'h06, "d2_sel");
        send_byte(8'h0A, "d2_pos");
        for (int i = 0; i < 20 && !tx_valid; i++) tick();
        held = tx_data;
        stable = 1;
        repeat (5) begin
            tick();
            if (!tx_valid || tx_data !== held) stable = 0;
        end
        check("d2_stall_stable", {31'd0, stable}, 32'd1);
        check("d2_stall_byte", {24'd0, held}, 32'h01);
        recv_byte(8'h01, "d2_valid");
        recv_byte(8'hC4, "d2_data");
        check("d2_sel", {29'd0, cpu_dmp_chip_select}, 32'd6);
        check("d2_pos", {27'd0, cpu_dmp_fifo_pos}, 32'h0A);
        repeat (2) tick();
        check("d2_sel_held", {29'd0, cpu_dmp_chip_select}, 32'd6);

        // Debug mode off, single step, unknown command, debug back on
        send_byte(8'h42, "b0_cmd");
        send_byte(8'h00, "b0_arg");
        recv_byte(8'h06, "b0_ack");
        check("b0_debug", {31'd0, cpu_debug}, 32'd0);
        nx0 = nx_cnt;
        send_byte(8'h53, "s_cmd");
        recv_byte(8'h06, "s_ack");
        check("s_step_count", nx_cnt - nx0, 32'd1);
        send_byte(8'h5A, "u_cmd");
        recv_byte(8'h15, "u_nak");
        check("u_idle", {30'd0, rx_ready, tx_valid}, 32'b10);
        send_byte(8'h42, "b1_cmd");
        send_byte(8'h01, "b1_arg");
        recv_byte(8'h06, "b1_ack");
        check("b1_debug", {31'd0, cpu_debug}, 32'd1);

        // Reset during PUSH wait
        cpu_in_full = 1'b1;
        wr0 = wr_cnt;
        send_byte(8'h49, "r1_cmd");
        send_byte(8'h99, "r1_arg");
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        check("r1_idle", {30'd0, rx_ready, tx_valid}, 32'b10);
        i_rst = 1'b1;
        cpu_in_full = 1'b0;
        repeat (3) tick();
        check("r1_no_wr", wr_cnt - wr0, 32'd0);
        check("r1_no_reply", {31'd0, tx_valid}, 32'd0);

        // Reset during SEND
        tx_ready = 1'b0;
        send_byte(8'h53, "r2_cmd");
        repeat (3) tick();
        check("r2_in_send", {31'd0, tx_valid}, 32'd1);
        i_rst = 1'b0;
        tick();
        check("r2_idle", {30'd0, rx_ready, tx_valid}, 32'b10);
        check("r2_strobes", {29'd0, cpu_in_wr, cpu_out_rd, cpu_nxtInstr}, 32'd0);
        i_rst = 1'b1;
        tx_ready = 1'b1;
        repeat (2) tick();
        check("r2_no_reply", {31'd0, tx_valid}, 32'd0);

        // Strobe shape across the whole run
        check("strobe_max_len", run_max, 32'd1);
        check("strobe_overlap", overlap, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
